// File: rtl/hbm_phy_responder_if.sv
// ============================================================================
// Module      : hbm_phy_responder_if
// Description : Controller-to-PHY command/response link for hbm_phy_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hbm_phy_responder_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
);
  logic              phy_cmd_valid;
  logic              phy_cmd;
  logic [ADDR_W-1:0] phy_addr;
  logic [DATA_W-1:0] phy_wr_data;
  logic              phy_ready;
  logic [DATA_W-1:0] phy_rd_data;
  logic              phy_rd_valid;
  logic              phy_error;
  logic [15:0]       err_count;

  modport master (
    output phy_cmd_valid, phy_cmd, phy_addr, phy_wr_data,
    input  phy_ready, phy_rd_data, phy_rd_valid, phy_error, err_count
  );

  modport slave (
    input  phy_cmd_valid, phy_cmd, phy_addr, phy_wr_data,
    output phy_ready, phy_rd_data, phy_rd_valid, phy_error, err_count
  );
endinterface

`default_nettype wire

// File: rtl/hbm_phy_responder.sv
// ============================================================================
// Module      : hbm_phy_responder
// Description : PHY-side responder with backing memory and programmable
//               write/read latencies; flags out-of-range addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hbm_phy_responder #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 6,
  parameter int WR_LAT = 2,
  parameter int RD_LAT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  hbm_phy_responder_if.slave  phy
);

  localparam int LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WR_LAT > 0) ? WR_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RESP = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              rd_valid_q;
  logic              error_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_buf_q;
  logic              rd_err_q;
  logic [15:0]       err_count_q;
  logic [15:0]       err_count_d;

  logic [DATA_W-1:0] mem_q [2**MEM_AW];

  logic              accept;
  logic              in_range;
  logic [MEM_AW-1:0] idx;
  logic              rd_done;
  logic              err_inc;

  assign in_range = (phy.phy_addr[ADDR_W-1:MEM_AW] == '0);
  assign idx      = phy.phy_addr[MEM_AW-1:0];
  assign accept   = phy.phy_cmd_valid & ready_q;
  assign rd_done  = (state_q == S_RD_WAIT) && (cnt_q == '0);

  // Errors are counted on the same edge that raises phy_error.
  assign err_inc     = (accept & phy.phy_cmd & ~in_range) | (rd_done & rd_err_q);
  assign err_count_d = (err_inc && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1
                                                               : err_count_q;

  // Backing store is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (accept && phy.phy_cmd && in_range) begin
      mem_q[idx] <= phy.phy_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_buf_q    <= '0;
      rd_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      rd_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= err_count_d;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (phy.phy_cmd) begin
              error_q <= ~in_range;
              if (WR_LAT > 0) begin
                state_q <= S_WR_BUSY;
                cnt_q   <= WR_LOAD;
                ready_q <= 1'b0;
              end
            end else begin
              rd_buf_q <= in_range ? mem_q[idx] : '0;
              rd_err_q <= ~in_range;
              state_q  <= S_RD_WAIT;
              cnt_q    <= RD_LOAD;
              ready_q  <= 1'b0;
            end
          end
        end
        S_WR_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (rd_done) begin
            state_q    <= S_RD_RESP;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_buf_q;
            error_q    <= rd_err_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RD_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign phy.phy_ready    = ready_q;
  assign phy.phy_rd_data  = rd_data_q;
  assign phy.phy_rd_valid = rd_valid_q;
  assign phy.phy_error    = error_q;
  assign phy.err_count    = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hbm_phy_responder.sv
// ============================================================================
// Module      : tb_hbm_phy_responder
// Description : Directed plus randomized bench for hbm_phy_responder with a
//               timing/memory reference model (WR_LAT=2 and WR_LAT=0 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hbm_phy_responder;

  localparam int RDL = 4;
  localparam int O_RDY = 0, O_RVL = 1, O_ERR = 2, O_CNT = 3, O_DAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hbm_phy_responder_if #(.DATA_W(512), .ADDR_W(32)) if0 ();
  hbm_phy_responder_if #(.DATA_W(512), .ADDR_W(32)) if1 ();

  hbm_phy_responder #(.DATA_W(512), .ADDR_W(32), .MEM_AW(6), .WR_LAT(2), .RD_LAT(RDL))
    u_dut (.clk(clk), .reset_n(rst_n), .phy(if0));
  hbm_phy_responder #(.DATA_W(512), .ADDR_W(32), .MEM_AW(6), .WR_LAT(0), .RD_LAT(RDL))
    u_dut0 (.clk(clk), .reset_n(rst_n), .phy(if1));

  logic [511:0] mm    [2][64];
  bit           known [2][64];
  int           exp_err [2];
  int           passed = 0;
  int           total  = 0;

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  function automatic int wr_lat_of(int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  function automatic logic [511:0] get(int sel, int which);
    logic [511:0] r;
    r = '0;
    if (sel == 0) begin
      case (which)
        O_RDY:   r[0] = if0.phy_ready;
        O_RVL:   r[0] = if0.phy_rd_valid;
        O_ERR:   r[0] = if0.phy_error;
        O_CNT:   r[15:0] = if0.err_count;
        default: r = if0.phy_rd_data;
      endcase
    end else begin
      case (which)
        O_RDY:   r[0] = if1.phy_ready;
        O_RVL:   r[0] = if1.phy_rd_valid;
        O_ERR:   r[0] = if1.phy_error;
        O_CNT:   r[15:0] = if1.err_count;
        default: r = if1.phy_rd_data;
      endcase
    end
    return r;
  endfunction

  task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drv(int sel, logic v, logic c, logic [31:0] a, logic [511:0] d);
    if (sel == 0) begin
      if0.phy_cmd_valid = v; if0.phy_cmd = c; if0.phy_addr = a; if0.phy_wr_data = d;
    end else begin
      if1.phy_cmd_valid = v; if1.phy_cmd = c; if1.phy_addr = a; if1.phy_wr_data = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err(int sel);
    if (exp_err[sel] < 65535) exp_err[sel]++;
  endtask

  task automatic do_write(int sel, logic [31:0] addr, logic [511:0] data);
    bit oor;
    int wl;
    oor = (addr[31:6] != 0);
    wl  = wr_lat_of(sel);
    check("wr_ready_before", get(sel, O_RDY), 1);
    drv(sel, 1'b1, 1'b1, addr, data);
    step();
    drv(sel, 1'b0, 1'b0, $urandom, rand512());
    if (!oor) begin
      mm[sel][addr[5:0]] = data;
      known[sel][addr[5:0]] = 1'b1;
    end else begin
      bump_err(sel);
    end
    for (int k = 0; k <= wl; k++) begin
      if (k > 0) step();
      check("wr_ready", get(sel, O_RDY), (k >= wl) ? 1 : 0);
      check("wr_error", get(sel, O_ERR), (k == 0 && oor) ? 1 : 0);
    end
    check("wr_err_count", get(sel, O_CNT), exp_err[sel]);
  endtask

  task automatic do_read(int sel, logic [31:0] addr, bit inject);
    bit oor;
    logic [511:0] exp;
    oor = (addr[31:6] != 0);
    exp = oor ? '0 : mm[sel][addr[5:0]];
    check("rd_ready_before", get(sel, O_RDY), 1);
    drv(sel, 1'b1, 1'b0, addr, rand512());
    step();
    drv(sel, 1'b0, 1'b0, $urandom, rand512());
    if (oor) bump_err(sel);
    for (int k = 0; k <= RDL + 1; k++) begin
      if (k > 0) step();
      if (inject && k == 1) drv(sel, 1'b1, 1'b1, 32'h10, rand512());
      if (inject && k == 2) drv(sel, 1'b0, 1'b0, 32'h0, '0);
      check("rd_ready", get(sel, O_RDY), (k == RDL + 1) ? 1 : 0);
      check("rd_valid", get(sel, O_RVL), (k == RDL) ? 1 : 0);
      check("rd_error", get(sel, O_ERR), (k == RDL && oor) ? 1 : 0);
      if (k >= RDL) check("rd_data", get(sel, O_DAT), exp);
      if (k == RDL) check("rd_err_count", get(sel, O_CNT), exp_err[sel]);
    end
  endtask

  task automatic quiet(int sel, int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("quiet_valid", get(sel, O_RVL), 0);
      check("quiet_ready", get(sel, O_RDY), 1);
    end
  endtask

  task automatic rand_ops(int sel, int n);
    logic [5:0] ix;
    for (int i = 0; i < n; i++) begin
      ix = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 5))
        0:       do_write(sel, 32'h40 | $urandom, rand512());
        1:       do_read(sel, 32'h40 | $urandom, 1'b0);
        2, 3:    do_write(sel, {26'd0, ix}, rand512());
        default: if (known[sel][ix]) do_read(sel, {26'd0, ix}, 1'b0);
                 else do_write(sel, {26'd0, ix}, rand512());
      endcase
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
  endtask

  initial begin
    logic [511:0] d4 [4];
    drv(0, 1'b0, 1'b0, '0, '0);
    drv(1, 1'b0, 1'b0, '0, '0);
    exp_err[0] = 0;
    exp_err[1] = 0;
    #1 rst_n = 1'b0;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", get(s, O_RDY), 0);
      check("rst_valid", get(s, O_RVL), 0);
      check("rst_error", get(s, O_ERR), 0);
      check("rst_count", get(s, O_CNT), 0);
      check("rst_data",  get(s, O_DAT), 0);
    end
    rst_n = 1'b1;
    step();
    check("rel_ready", get(0, O_RDY), 1);
    check("rel_ready0", get(1, O_RDY), 1);

    do_write(0, 32'h10, {16{32'hDEADBEEF}});
    do_read(0, 32'h10, 1'b0);
    do_write(0, 32'h00, {16{32'hCAFEF00D}});
    do_read(0, 32'h40, 1'b0);
    do_write(0, 32'h40, rand512());
    do_read(0, 32'h00, 1'b0);

    // Command offered during RD_WAIT must be dropped.
    do_read(0, 32'h10, 1'b1);
    quiet(0, 4);
    do_read(0, 32'h10, 1'b0);

    for (int i = 0; i < 4; i++) d4[i] = rand512();
    for (int i = 0; i < 4; i++) begin
      check("wl0_ready_before", get(1, O_RDY), 1);
      drv(1, 1'b1, 1'b1, i, d4[i]);
      step();
      mm[1][i] = d4[i];
      known[1][i] = 1'b1;
      check("wl0_ready", get(1, O_RDY), 1);
      check("wl0_error", get(1, O_ERR), 0);
    end
    drv(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) do_read(1, i, 1'b0);

    rand_ops(0, 24);
    rand_ops(1, 12);

    do_write(0, 32'h10, {16{32'h0BADC0DE}});
    check("pre_rst_ready", get(0, O_RDY), 1);
    drv(0, 1'b1, 1'b0, 32'h10, '0);
    step();
    drv(0, 1'b0, 1'b0, '0, '0);
    step();
    step();
    rst_n = 1'b0;
    exp_err[0] = 0;
    exp_err[1] = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mid_rst_valid", get(0, O_RVL), 0);
      check("mid_rst_ready", get(0, O_RDY), 0);
    end
    rst_n = 1'b1;
    quiet(0, 6);
    check("post_rst_count", get(0, O_CNT), 0);
    do_read(0, 32'h10, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hbm_phy_responder.md
Name: hbm_phy_responder

Overview:
- Behavioural/synthesizable PHY-side responder for the HBM controller's PHY interface: the target end of the phy_cmd/phy_addr/phy_wr_data/phy_rd_data/phy_ready/phy_error link.
- Accepts one command at a time and holds a small backing memory.
- Applies programmable write and read latencies, returns read data with a valid strobe, and flags out-of-range addresses.
- Used as the PHY stand-in under the controller in system benches and FPGA bring-up.

Parameters:
- DATA_W, 512, data bus width.
- ADDR_W, 32, phy_addr width.
- MEM_AW, 6, backing-memory index width (2^MEM_AW words of DATA_W bits).
- WR_LAT, 2, busy cycles after a write is accepted (0 allowed).
- RD_LAT, 4, cycles from read acceptance to data return (minimum 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- phy_cmd_valid  in  1  command present this cycle.
- phy_cmd  in  1  1 = write, 0 = read.
- phy_addr  in  ADDR_W  word address.
- phy_wr_data  in  DATA_W  write data.
- phy_ready  out  1  responder can accept a command.
- phy_rd_data  out  DATA_W  read return data.
- phy_rd_valid  out  1  one-cycle strobe, phy_rd_data valid.
- phy_error  out  1  one-cycle error strobe.
- err_count  out  16  saturating count of errored commands.

Behaviour:
- Reset (async assert, sync release): state IDLE; phy_ready=1 after release (0 while reset_n=0); phy_rd_data=0; phy_rd_valid=0; phy_error=0; err_count=0; latency counter=0. Memory contents are NOT reset.
- Acceptance: a command is accepted at rising edge N when phy_cmd_valid=1 and phy_ready=1. phy_cmd_valid while phy_ready=0 is ignored, with no side effects.
- Address check: in range iff phy_addr[ADDR_W-1:MEM_AW]==0. Index = phy_addr[MEM_AW-1:0].
- States:
  - IDLE: phy_ready=1.
  - WR_BUSY: phy_ready=0.
  - RD_WAIT: phy_ready=0.
  - RD_RESP: phy_ready=0.
- Write accepted at edge N:
  - In range: mem[index] <= phy_wr_data at edge N.
  - WR_LAT=0: remain IDLE; back-to-back writes at one per cycle.
  - WR_LAT>0: go to WR_BUSY at N; return to IDLE at edge N+WR_LAT, so phy_ready=1 again after edge N+WR_LAT.
- Read accepted at edge N:
  - Data mem[index] is captured at N, so a same-edge concurrent write is impossible.
  - Go to RD_WAIT; counter counts RD_LAT-1 cycles.
  - At edge N+RD_LAT enter RD_RESP with phy_rd_valid=1 and phy_rd_data=captured word, for exactly one cycle.
  - At edge N+RD_LAT+1 return to IDLE; phy_rd_valid=0. phy_rd_data holds its last value.
- Write-then-read: a read accepted at any edge after the write's acceptance edge returns the new data.
- Out-of-range write: memory untouched; phy_error=1 for the cycle after edge N; latency/state handling as a normal write.
- Out-of-range read: normal latency; on the RD_RESP cycle phy_rd_data=0, phy_rd_valid=1 and phy_error=1 together.
- err_count: increments by 1 per errored command at the cycle its phy_error asserts; saturates at 16'hFFFF.
- Reset mid-operation: any in-flight read is discarded with no phy_rd_valid; the bus returns to IDLE with phy_ready=1 after release. Memory writes completed before reset persist.
- phy_cmd_valid and phy_cmd are sampled only on the acceptance edge. phy_addr and phy_wr_data need only be stable at that edge.

Test Plan:
- Reset release, then write addr 0x10 (in range for MEM_AW=6? no: 0x10 = 16 < 64, yes) with data 512'hDEADBEEF…DEADBEEF, WR_LAT=2 -> phy_ready low for exactly 2 cycles after acceptance; phy_error stays 0.
- Read 0x10 after that write -> phy_rd_valid is a single pulse exactly 4 cycles after acceptance (RD_LAT=4); phy_rd_data=written pattern; phy_ready returns high the following cycle.
- Read 0x40 (out of range) -> phy_rd_valid and phy_error both pulse at acceptance+4; phy_rd_data=0; err_count=1. Then write 0x40 -> phy_error pulses the cycle after acceptance; err_count=2; mem[0] unchanged (verified by reading 0x00).
- WR_LAT=0 build: writes to 0..3 on four consecutive edges -> all accepted with phy_ready constantly 1; reads of each return the matching data.
- phy_cmd_valid pulsed while phy_ready=0 during RD_WAIT -> ignored: no memory change, no extra response.
- Assert reset_n=0 two cycles after a read is accepted -> no phy_rd_valid is ever produced; after release phy_ready=1 and a prior write to 0x10 still reads back correctly.
